// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/allowin handshake, flush, optional
// skid entry (registered in_allowin) and a saturating stall counter.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int SKID  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_allowin,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_allowin,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [CNT_W-1:0] stall_cnt_p1;
  logic             stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign stall = vld_p1 && !out_allowin;

  if (SKID == 0) begin : g_single
    assign in_allowin = !vld_p1 || out_allowin;

    // stage p1: single main entry
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else if (flush) begin
        vld_p1 <= 1'b0;
      end else if (in_allowin) begin
        vld_p1 <= in_valid;
        if (in_valid) data_p1 <= in_data;
      end
    end
  end else begin : g_skid
    logic             skid_vld_p1;
    logic [WIDTH-1:0] skid_data_p1;
    logic             xfer_in;
    logic             xfer_out;

    // allowin comes straight from a flop, so no path from out_allowin
    assign in_allowin = !skid_vld_p1;
    assign xfer_in    = in_valid && in_allowin;
    assign xfer_out   = vld_p1 && out_allowin;

    // stage p1: main entry plus skid entry; skid always drains into main first
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1       <= 1'b0;
        data_p1      <= '0;
        skid_vld_p1  <= 1'b0;
        skid_data_p1 <= '0;
      end else if (flush) begin
        vld_p1      <= 1'b0;
        skid_vld_p1 <= 1'b0;
      end else if (skid_vld_p1) begin
        if (xfer_out) begin
          data_p1     <= skid_data_p1;
          skid_vld_p1 <= 1'b0;
        end
      end else if (xfer_in) begin
        if (!vld_p1 || xfer_out) begin
          vld_p1  <= 1'b1;
          data_p1 <= in_data;
        end else begin
          skid_vld_p1  <= 1'b1;
          skid_data_p1 <= in_data;
        end
      end else if (xfer_out) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt_p1 <= '0;
    else if (stall) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign stall_cnt = stall_cnt_p1;

endmodule
